// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the 2-way set-associative cache.
package cache_pkg;

  localparam int ADDR_WIDTH_D = 16;
  localparam int DATA_WIDTH_D = 16;
  localparam int SETS_D       = 64;
  localparam int LINE_WORDS_D = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set valid/dirty/tag plus line data storage and hit compare.
module cache_way #(
  parameter int TAG_W      = 6,
  parameter int IDX_W      = 6,
  parameter int WRD_W      = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      idx,
  input  logic [WRD_W-1:0]      word,
  input  logic [TAG_W-1:0]      tag,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  set_dirty,
  input  logic                  clr_dirty,
  input  logic                  fill_done,
  output logic                  hit,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_W-1:0]      line_tag,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int SETS  = 1 << IDX_W;
  localparam int WORDS = SETS * (1 << WRD_W);

  logic [SETS-1:0]       vld, drt;
  logic [TAG_W-1:0]      tags  [SETS];
  logic [DATA_WIDTH-1:0] words [WORDS];

  assign valid    = vld[idx];
  assign dirty    = drt[idx];
  assign line_tag = tags[idx];
  assign hit      = valid && (line_tag == tag);
  assign rdata    = words[{idx, word}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      drt <= '0;
    end else if (fill_done) begin
      vld[idx] <= 1'b1;
      drt[idx] <= 1'b0;
    end else if (clr_dirty) begin
      drt[idx] <= 1'b0;
    end else if (set_dirty) begin
      drt[idx] <= 1'b1;
    end
  end

  // Tags and data are plain storage; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_done) tags[idx] <= tag;
    if (wr_en)     words[{idx, word}] <= wdata;
  end

endmodule

// File: rtl/assoc_cache.sv
// 2-way set-associative write-back/write-allocate cache with a beat-serial memory port.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int SETS       = SETS_D,
  parameter int LINE_WORDS = LINE_WORDS_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_valid
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WRD_W  = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - WRD_W - 1;
  localparam int BEAT_W = WRD_W + 1;

  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [WRD_W-1:0] a_word;
  logic             unused_byte_bit;

  assign a_tag           = addr[ADDR_WIDTH-1 -: TAG_W];
  assign a_idx           = addr[WRD_W+1 +: IDX_W];
  assign a_word          = addr[1 +: WRD_W];
  assign unused_byte_bit = addr[0];

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic              victim;
  logic [SETS-1:0]   lru;

  logic [1:0]                 hit_w, vld_w, drt_w;
  logic [1:0][TAG_W-1:0]      tag_w;
  logic [1:0][DATA_WIDTH-1:0] rd_w;
  logic [1:0]                 wr_w, setd_w, clrd_w, fill_w;

  logic                  any_hit, hit_way, miss_victim, idle_hit, last_beat, beat_ok;
  logic [1:0]            hit_sel, vic_sel;
  logic [WRD_W-1:0]      way_word;
  logic [DATA_WIDTH-1:0] way_wdata;

  assign any_hit     = |hit_w;
  assign hit_way     = !hit_w[0];  // both-hit resolves to way 0
  assign miss_victim = !vld_w[0] ? 1'b0 : (!vld_w[1] ? 1'b1 : lru[a_idx]);
  assign idle_hit    = (state == IDLE) && enable && any_hit;
  assign last_beat   = (beat == BEAT_W'(LINE_WORDS - 1));
  assign beat_ok     = (state != IDLE) && mem_valid;
  assign hit_sel     = hit_way ? 2'b10 : 2'b01;
  assign vic_sel     = victim  ? 2'b10 : 2'b01;
  assign way_word    = (state == IDLE) ? a_word : beat[WRD_W-1:0];
  assign way_wdata   = (state == FILL) ? mem_data_in : data_in;

  assign wr_w   = (idle_hit && wr) ? hit_sel : ((state == FILL && mem_valid) ? vic_sel : 2'b00);
  assign setd_w = (idle_hit && wr) ? hit_sel : 2'b00;
  assign clrd_w = (state == EVICT && mem_valid && last_beat) ? vic_sel : 2'b00;
  assign fill_w = (state == FILL  && mem_valid && last_beat) ? vic_sel : 2'b00;

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way #(
      .TAG_W(TAG_W), .IDX_W(IDX_W), .WRD_W(WRD_W), .DATA_WIDTH(DATA_WIDTH)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .idx      (a_idx),
      .word     (way_word),
      .tag      (a_tag),
      .wr_en    (wr_w[g]),
      .wdata    (way_wdata),
      .set_dirty(setd_w[g]),
      .clr_dirty(clrd_w[g]),
      .fill_done(fill_w[g]),
      .hit      (hit_w[g]),
      .valid    (vld_w[g]),
      .dirty    (drt_w[g]),
      .line_tag (tag_w[g]),
      .rdata    (rd_w[g])
    );
  end

  assign data_out     = rd_w[hit_way];
  assign mem_data_out = rd_w[victim];
  assign mem_addr     = {(state == EVICT) ? tag_w[victim] : a_tag, a_idx, beat[WRD_W-1:0], 1'b0};
  // Stall is forced low while reset is held so the CPU sees an idle cache at once.
  assign stall        = rst && ((state != IDLE) || (enable && !any_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      beat    <= '0;
      victim  <= 1'b0;
      lru     <= '0;
      mem_req <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any_hit) begin
            lru[a_idx] <= !hit_way;
          end else if (enable) begin
            victim  <= miss_victim;
            beat    <= '0;
            mem_req <= 1'b1;
            if (vld_w[miss_victim] && drt_w[miss_victim]) begin
              state  <= EVICT;
              mem_wr <= 1'b1;
            end else begin
              state  <= FILL;
              mem_wr <= 1'b0;
            end
          end
        end
        EVICT: if (beat_ok) begin
          if (last_beat) begin
            state  <= FILL;
            beat   <= '0;
            mem_wr <= 1'b0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        FILL: if (beat_ok) begin
          if (last_beat) begin
            state   <= IDLE;
            beat    <= '0;
            mem_req <= 1'b0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache against a word-addressed backing memory model.
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out, mem_addr, mem_data_out, mem_data_in;
  logic        stall, mem_req, mem_wr, mem_valid;
  logic        mem_ok = 1'b1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_valid(mem_valid)
  );

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return {a[15:1], 1'b0} ^ 16'hC3A5;
  endfunction

  // Backing memory: untouched words read as init_word, written-back words overlay it.
  bit          wflag [32768];
  logic [15:0] wmem  [32768];
  int          fill_cnt = 0, wb_cnt = 0;
  logic [15:0] wb_addr_log [256], wb_data_log [256], fill_addr_log [256];

  assign mem_valid   = mem_ok;
  assign mem_data_in = wflag[mem_addr[15:1]] ? wmem[mem_addr[15:1]] : init_word(mem_addr);

  always @(posedge clk) begin
    if (mem_req && mem_valid) begin
      if (mem_wr) begin
        wflag[mem_addr[15:1]] <= 1'b1;
        wmem[mem_addr[15:1]]  <= mem_data_out;
        wb_addr_log[wb_cnt[7:0]] <= mem_addr;
        wb_data_log[wb_cnt[7:0]] <= mem_data_out;
        wb_cnt <= wb_cnt + 1;
      end else begin
        fill_addr_log[fill_cnt[7:0]] <= mem_addr;
        fill_cnt <= fill_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one access at a negedge and holds it until stall drops; returns cycles taken.
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int cyc);
    @(negedge clk);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    cyc = 0; rd = '0;
    forever begin
      #1;
      cyc++;
      if (!stall) begin
        rd = data_out;
        break;
      end
      if (cyc >= 100) begin
        chk("access_timeout", 32'(stall), 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    enable = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int cyc, f0, w0, n;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Cold read miss: 8-beat fill, 10-cycle access.
    f0 = fill_cnt;
    access(1'b0, 16'h1230, 16'h0, rd, cyc);
    chk("cold_cycles", 32'(cyc), 32'd10);
    chk("cold_data", 32'(rd), 32'(init_word(16'h1230)));
    chk("cold_fill_beats", 32'(fill_cnt - f0), 32'd8);
    chk("cold_fill_first", 32'(fill_addr_log[f0[7:0]]), 32'h1230);
    chk("cold_fill_last", 32'(fill_addr_log[8'(f0 + 7)]), 32'h123E);

    // Write hit then read hit, no traffic.
    f0 = fill_cnt; w0 = wb_cnt;
    access(1'b1, 16'h1232, 16'hBEEF, rd, cyc);
    chk("wr_hit_cycles", 32'(cyc), 32'd1);
    access(1'b0, 16'h1232, 16'h0, rd, cyc);
    chk("rd_hit_cycles", 32'(cyc), 32'd1);
    chk("rd_hit_data", 32'(rd), 32'hBEEF);
    chk("hit_no_traffic", 32'((fill_cnt - f0) + (wb_cnt - w0)), 32'd0);

    // Second tag fills the invalid way.
    access(1'b0, 16'h5230, 16'h0, rd, cyc);
    chk("way1_cycles", 32'(cyc), 32'd10);
    chk("way1_data", 32'(rd), 32'(init_word(16'h5230)));

    // Third tag evicts the dirty LRU line first.
    f0 = fill_cnt; w0 = wb_cnt;
    access(1'b0, 16'h9230, 16'h0, rd, cyc);
    chk("evict_cycles", 32'(cyc), 32'd18);
    chk("evict_beats", 32'(wb_cnt - w0), 32'd8);
    chk("evict_addr0", 32'(wb_addr_log[w0[7:0]]), 32'h1230);
    chk("evict_data0", 32'(wb_data_log[w0[7:0]]), 32'(init_word(16'h1230)));
    chk("evict_data1", 32'(wb_data_log[8'(w0 + 1)]), 32'hBEEF);
    chk("evict_addr7", 32'(wb_addr_log[8'(w0 + 7)]), 32'h123E);
    chk("evict_fill_beats", 32'(fill_cnt - f0), 32'd8);
    chk("evict_fill_first", 32'(fill_addr_log[f0[7:0]]), 32'h9230);
    chk("evict_rd_data", 32'(rd), 32'(init_word(16'h9230)));

    // Written-back word returns from memory; clean 0x5230 line is the victim.
    w0 = wb_cnt;
    access(1'b0, 16'h1232, 16'h0, rd, cyc);
    chk("refetch_cycles", 32'(cyc), 32'd10);
    chk("refetch_data", 32'(rd), 32'hBEEF);
    chk("refetch_no_wb", 32'(wb_cnt - w0), 32'd0);

    // mem_valid withheld for 5 cycles during fill beat 3.
    f0 = fill_cnt;
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = 16'h2004;
    repeat (4) @(negedge clk);
    mem_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_addr", 32'(mem_addr), 32'h2006);
      chk("hold_stall", 32'(stall), 32'd1);
      @(negedge clk);
    end
    chk("hold_beats_done", 32'(fill_cnt - f0), 32'd3);
    mem_ok = 1'b1;
    #1;
    n = 0;
    while (stall && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("hold_resume_cycles", 32'(n), 32'd5);
    chk("hold_data", 32'(data_out), 32'(init_word(16'h2004)));
    chk("hold_fill_beats", 32'(fill_cnt - f0), 32'd8);
    @(posedge clk);
    #1;
    enable = 1'b0;

    // Reset during fill beat 3 aborts the burst.
    f0 = fill_cnt;
    @(negedge clk);
    enable = 1'b1; addr = 16'h3000;
    repeat (4) @(negedge clk);
    #1;
    chk("abort_addr", 32'(mem_addr), 32'h3006);
    rst = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    chk("abort_beats", 32'(fill_cnt - f0), 32'd3);

    f0 = fill_cnt;
    access(1'b0, 16'h3000, 16'h0, rd, cyc);
    chk("refill_cycles", 32'(cyc), 32'd10);
    chk("refill_beats", 32'(fill_cnt - f0), 32'd8);
    chk("refill_first", 32'(fill_addr_log[f0[7:0]]), 32'h3000);
    chk("refill_data", 32'(rd), 32'(init_word(16'h3000)));

    // Reset invalidated the earlier 0x2004 line.
    access(1'b0, 16'h2004, 16'h0, rd, cyc);
    chk("post_rst_miss_cycles", 32'(cyc), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
